// File: rtl/dense_argmax_stream_if.sv
// ---------------------------------------------------------------------------
// dense_argmax_stream_if
// Bundles the vector input handshake, the weight/bias memory port, and the
// argmax result handshake of dense_argmax_stream.
//
// Handshake rule for both in_* and out_*: a transfer happens on the rising
// clock edge where valid and ready are both high. The producer holds valid
// and its payload steady until that edge. Ready may be high with valid low.
//
// Signals:
//   in_valid / in_ready / x   : input vector handshake
//   w_rd_en / w_addr          : read strobe and pass address to the memory
//   w_data / b_data           : memory read data, one cycle after w_rd_en
//   out_valid / out_ready     : result handshake
//   y_onehot / y_idx / y_max  : argmax result
//   busy / dbg_state          : activity flag and raw FSM state for debug
//
// Modports:
//   slave  : the dense layer itself
//   master : the environment (upstream source, weight memory, downstream sink)
// ---------------------------------------------------------------------------
interface dense_argmax_stream_if #(
    parameter int M     = 10,
    parameter int N     = 100,
    parameter int LANES = 10,
    parameter int DW    = 16,
    parameter int IDXW  = 8,
    parameter int PW    = 4
);
    logic                    in_valid;
    logic                    in_ready;
    logic [DW*M-1:0]         x;
    logic                    w_rd_en;
    logic [PW-1:0]           w_addr;
    logic [DW*M*LANES-1:0]   w_data;
    logic [DW*LANES-1:0]     b_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [N-1:0]            y_onehot;
    logic [IDXW-1:0]         y_idx;
    logic [DW-1:0]           y_max;
    logic                    busy;
    logic [1:0]              dbg_state;

    modport slave (
        input  in_valid, x, w_data, b_data, out_ready,
        output in_ready, w_rd_en, w_addr, out_valid, y_onehot, y_idx, y_max,
               busy, dbg_state
    );

    modport master (
        output in_valid, x, w_data, b_data, out_ready,
        input  in_ready, w_rd_en, w_addr, out_valid, y_onehot, y_idx, y_max,
               busy, dbg_state
    );
endinterface

// File: rtl/dense_argmax_stream.sv
// ---------------------------------------------------------------------------
// dense_argmax_stream
// Time-multiplexed final dense layer with argmax. One input vector is
// accepted per handshake. The layer then streams P = ceil(N/LANES) passes of
// weights and biases from an external synchronous memory, computes
// y = sat(sum(x*w) + b) for LANES neurons per pass, and returns the index,
// value and one-hot encoding of the largest neuron output.
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset; aborts any vector in flight
//   bus    : dense_argmax_stream_if.slave (handshakes, memory port, result,
//            busy, dbg_state)
//
// Pipeline, counted from the request for pass p issued after edge E(p):
//   memory data valid after E(p+1), S1 products at E(p+2), S2 lane sums at
//   E(p+3), S3 bias + saturate at E(p+4), S4 argmax update at E(p+5).
// ---------------------------------------------------------------------------
module dense_argmax_stream #(
    parameter int M     = 10,
    parameter int N     = 100,
    parameter int LANES = 10,
    parameter int DW    = 16,
    parameter int FRAC  = 15,
    parameter int IDXW  = 8,
    parameter int P     = (N + LANES - 1) / LANES,
    parameter int PW    = (P > 1) ? $clog2(P) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dense_argmax_stream_if.slave bus
);
    // Lane sum width holds M full products without overflow; one extra bit
    // absorbs the bias before saturation.
    localparam int SW = 2 * DW + $clog2(M);
    localparam int TW = SW + 1;
    localparam logic signed [DW-1:0] Y_MIN  = {1'b1, {(DW-1){1'b0}}};
    localparam logic signed [TW-1:0] SAT_HI = {{(TW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [TW-1:0] SAT_LO = {{(TW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;

    state_t               state_q;
    logic                 w_rd_en_q;
    logic [PW-1:0]        w_addr_q;
    logic                 out_valid_q;
    logic [N-1:0]         y_onehot_q;
    logic [IDXW-1:0]      y_idx_q;
    logic [DW-1:0]        y_max_q;
    logic signed [DW-1:0] max_q;
    logic [IDXW-1:0]      idx_q;
    logic [DW*M-1:0]      x_q;

    // Stage valids and the pass index travelling with each stage.
    logic                 rd_v_q, v1_q, v2_q, v3_q;
    logic [PW-1:0]        rd_p_q, p1_q, p2_q, p3_q;

    logic signed [DW-1:0]   xs      [M];
    logic signed [DW-1:0]   ws      [LANES*M];
    logic signed [DW-1:0]   bs      [LANES];
    logic signed [2*DW-1:0] prod_d  [LANES*M];
    logic signed [2*DW-1:0] prod_q  [LANES*M];
    logic signed [DW-1:0]   b1_q    [LANES];
    logic signed [DW-1:0]   b2_q    [LANES];
    logic signed [SW-1:0]   sum_d   [LANES];
    logic signed [SW-1:0]   sum_q   [LANES];
    logic signed [TW-1:0]   tot_d   [LANES];
    logic signed [DW-1:0]   sat_d   [LANES];
    logic signed [DW-1:0]   y3_q    [LANES];

    logic signed [DW-1:0] best_v;
    logic [IDXW-1:0]      best_i;
    logic [N-1:0]         best_oh;

    always_comb begin
        for (int j = 0; j < M; j++)         xs[j] = x_q[DW*j +: DW];
        for (int k = 0; k < LANES*M; k++)   ws[k] = bus.w_data[DW*k +: DW];
        for (int l = 0; l < LANES; l++)     bs[l] = bus.b_data[DW*l +: DW];
    end

    // S1: full-width signed product, then floor shift back to Q format.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            for (int j = 0; j < M; j++) begin
                prod_d[l*M+j] = ((2*DW)'(xs[j]) * (2*DW)'(ws[l*M+j])) >>> FRAC;
            end
        end
    end

    // S2: per-lane sum of the M products.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            sum_d[l] = '0;
            for (int j = 0; j < M; j++) begin
                sum_d[l] = sum_d[l] + SW'(prod_q[l*M+j]);
            end
        end
    end

    // S3: bias add and saturation to the DW range.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            tot_d[l] = TW'(sum_q[l]) + TW'(b2_q[l]);
            if (tot_d[l] > SAT_HI)      sat_d[l] = SAT_HI[DW-1:0];
            else if (tot_d[l] < SAT_LO) sat_d[l] = SAT_LO[DW-1:0];
            else                        sat_d[l] = tot_d[l][DW-1:0];
        end
    end

    // S4: lanes scanned in ascending neuron order with a strict compare, so
    // the lowest index keeps a tie. Padding lanes past N never compete.
    always_comb begin
        best_v = max_q;
        best_i = idx_q;
        for (int l = 0; l < LANES; l++) begin
            if ((int'(p3_q) * LANES + l) < N && y3_q[l] > best_v) begin
                best_v = y3_q[l];
                best_i = IDXW'(int'(p3_q) * LANES + l);
            end
        end
    end

    always_comb begin
        best_oh = '0;
        for (int k = 0; k < N; k++) best_oh[k] = (int'(best_i) == k);
    end

    // Datapath registers carry no reset; the stage valids below qualify them.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && bus.in_valid) x_q <= bus.x;
        for (int k = 0; k < LANES*M; k++) prod_q[k] <= prod_d[k];
        for (int l = 0; l < LANES; l++) begin
            b1_q[l]  <= bs[l];
            b2_q[l]  <= b1_q[l];
            sum_q[l] <= sum_d[l];
            y3_q[l]  <= sat_d[l];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_v_q <= 1'b0;
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            rd_p_q <= '0;
            p1_q   <= '0;
            p2_q   <= '0;
            p3_q   <= '0;
        end else begin
            rd_v_q <= w_rd_en_q;
            v1_q   <= rd_v_q;
            v2_q   <= v1_q;
            v3_q   <= v2_q;
            rd_p_q <= w_addr_q;
            p1_q   <= rd_p_q;
            p2_q   <= p1_q;
            p3_q   <= p2_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            w_rd_en_q   <= 1'b0;
            w_addr_q    <= '0;
            out_valid_q <= 1'b0;
            y_onehot_q  <= '0;
            y_idx_q     <= '0;
            y_max_q     <= '0;
            max_q       <= Y_MIN;
            idx_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        state_q   <= RUN;
                        w_rd_en_q <= 1'b1;
                        w_addr_q  <= '0;
                        max_q     <= Y_MIN;
                        idx_q     <= '0;
                    end
                end
                RUN: begin
                    if (w_rd_en_q) begin
                        if (w_addr_q == PW'(P - 1)) w_rd_en_q <= 1'b0;
                        else                        w_addr_q  <= w_addr_q + 1'b1;
                    end
                    if (v3_q) begin
                        max_q <= best_v;
                        idx_q <= best_i;
                        if (p3_q == PW'(P - 1)) begin
                            y_idx_q     <= best_i;
                            y_max_q     <= best_v;
                            y_onehot_q  <= best_oh;
                            out_valid_q <= 1'b1;
                            state_q     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.w_rd_en   = w_rd_en_q;
    assign bus.w_addr    = w_addr_q;
    assign bus.out_valid = out_valid_q;
    assign bus.y_onehot  = y_onehot_q;
    assign bus.y_idx     = y_idx_q;
    assign bus.y_max     = y_max_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_dense_argmax_stream.sv
// ---------------------------------------------------------------------------
// tb_dense_argmax_stream
// Drives two instances of dense_argmax_stream: dut_a at the default sizes
// (N=100) and dut_b with N=95 so the last pass carries five padding lanes.
// Each instance has a small synchronous weight/bias memory model. Expected
// results come from a neuron-by-neuron reference computed with plain
// arithmetic, or from hand-derived constants in the vector table.
// ---------------------------------------------------------------------------
module tb_dense_argmax_stream;
    localparam int M = 10, N = 100, NB = 95, LANES = 10, DW = 16, FRAC = 15;
    localparam int IDXW = 8, P = 10, PW = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dense_argmax_stream_if #(.M(M), .N(N),  .LANES(LANES), .DW(DW), .IDXW(IDXW), .PW(PW)) ia ();
    dense_argmax_stream_if #(.M(M), .N(NB), .LANES(LANES), .DW(DW), .IDXW(IDXW), .PW(PW)) ib ();

    dense_argmax_stream #(.M(M), .N(N), .LANES(LANES), .DW(DW), .FRAC(FRAC), .IDXW(IDXW))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    dense_argmax_stream #(.M(M), .N(NB), .LANES(LANES), .DW(DW), .FRAC(FRAC), .IDXW(IDXW))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

    // Memory contents, indexed by neuron (padding neurons included).
    logic signed [DW-1:0] wA [P*LANES*M];
    logic signed [DW-1:0] bA [P*LANES];
    logic signed [DW-1:0] wB [P*LANES*M];
    logic signed [DW-1:0] bB [P*LANES];

    always @(posedge clk) begin
        if (ia.w_rd_en) begin
            for (int k = 0; k < LANES*M; k++) ia.w_data[DW*k +: DW] <= wA[int'(ia.w_addr)*LANES*M + k];
            for (int l = 0; l < LANES; l++)   ia.b_data[DW*l +: DW] <= bA[int'(ia.w_addr)*LANES + l];
        end
        if (ib.w_rd_en) begin
            for (int k = 0; k < LANES*M; k++) ib.w_data[DW*k +: DW] <= wB[int'(ib.w_addr)*LANES*M + k];
            for (int l = 0; l < LANES; l++)   ib.b_data[DW*l +: DW] <= bB[int'(ib.w_addr)*LANES + l];
        end
    end

    int n_vec = 0;
    int n_err = 0;
    logic [IDXW+DW-1:0] exp_q [$];
    logic [IDXW+DW-1:0] last_exp;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: evaluate every real neuron, then pick the first maximum.
    function automatic logic [IDXW+DW-1:0] ref_argmax(input logic [DW*M-1:0] xin,
                                                      input int n, input bit sel_b);
        longint best_v, acc, v;
        int best_i;
        logic signed [DW-1:0] xe, we, be;
        best_v = 0;
        best_i = 0;
        for (int k = 0; k < n; k++) begin
            acc = 0;
            for (int j = 0; j < M; j++) begin
                xe = xin[DW*j +: DW];
                we = sel_b ? wB[k*M+j] : wA[k*M+j];
                acc += (longint'(xe) * longint'(we)) >>> FRAC;
            end
            be = sel_b ? bB[k] : bA[k];
            v = acc + longint'(be);
            if (v > 32767) v = 32767;
            else if (v < -32768) v = -32768;
            if (k == 0 || v > best_v) begin
                best_v = v;
                best_i = k;
            end
        end
        return {IDXW'(best_i), DW'(best_v)};
    endfunction

    task automatic load_pattern(input int pat);
        for (int k = 0; k < P*LANES*M; k++) wA[k] = '0;
        for (int k = 0; k < P*LANES; k++)   bA[k] = '0;
        case (pat)
            0: for (int j = 0; j < M; j++) wA[37*M+j] = 16'h2000;
            1: for (int k = 0; k < N; k++) bA[k] = DW'(k - 50);
            3: for (int k = 0; k < N; k++) bA[k] = 16'h8000;
            4: begin
                bA[12] = 16'h1234;
                bA[88] = 16'h1234;
            end
            5: begin
                for (int j = 0; j < M; j++) wA[63*M+j] = 16'hC000;
                for (int k = 0; k < N; k++) if (k != 63) bA[k] = -16'sd2;
            end
            6: begin
                for (int j = 0; j < M; j++) wA[3*M+j] = 16'h0001;
                for (int k = 0; k < N; k++) if (k != 3) bA[k] = -16'sd20;
            end
            10: begin
                for (int k = 0; k < P*LANES*M; k++) wA[k] = DW'($urandom);
                for (int k = 0; k < P*LANES; k++)   bA[k] = DW'($urandom);
            end
            11: begin
                for (int k = 0; k < P*LANES*M; k++) wA[k] = DW'(int'($urandom_range(0, 2047)) - 1024);
                for (int k = 0; k < P*LANES; k++)   bA[k] = DW'(int'($urandom_range(0, 511)) - 256);
            end
            default: ;
        endcase
    endtask

    // Handshake one vector into dut_a and follow it to out_valid, checking
    // the read strobe/address sequence and the handshake-to-result latency.
    task automatic launch_a(input logic [DW*M-1:0] xin);
        int guard;
        int lat;
        int addr_bad;
        logic [31:0] rd_hist;
        ia.x = xin;
        ia.in_valid = 1'b1;
        guard = 0;
        while (ia.in_ready !== 1'b1 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        ia.in_valid = 1'b0;
        lat = 0;
        addr_bad = 0;
        rd_hist = '0;
        while (ia.out_valid !== 1'b1 && lat < 100) begin
            if (ia.w_rd_en === 1'b1) begin
                if (lat < 32) rd_hist[lat] = 1'b1;
                if (ia.w_addr !== PW'(lat)) addr_bad++;
            end
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, P + 4);
        check("rd_en_seq", rd_hist, (32'd1 << P) - 1);
        check("rd_addr_seq", addr_bad, 0);
    endtask

    task automatic check_result_a(input string tag);
        logic [N-1:0] oh;
        last_exp = exp_q.pop_front();
        oh = '0;
        oh[last_exp[IDXW+DW-1:DW]] = 1'b1;
        check({tag, "_idx"}, ia.y_idx, last_exp[IDXW+DW-1:DW]);
        check({tag, "_max"}, ia.y_max, last_exp[DW-1:0]);
        check({tag, "_onehot"}, ia.y_onehot, oh);
        check({tag, "_busy_ready"}, {ia.busy, ia.in_ready}, 2'b10);
    endtask

    task automatic release_a();
        ia.out_ready = 1'b1;
        @(posedge clk); #1;
        ia.out_ready = 1'b0;
        check("release_out_valid", ia.out_valid, 1'b0);
        check("release_in_ready", ia.in_ready, 1'b1);
    endtask

    typedef struct {
        string          name;
        int             pat;
        logic [DW-1:0]  x_fill;
        int             exp_idx;
        logic [DW-1:0]  exp_max;
    } vec_t;

    vec_t tbl [7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time %0t exceeded the run limit", $time);
        $fatal(1);
    end

    initial begin
        logic [DW*M-1:0] xr, x2;
        logic [NB-1:0]   ohb;
        int bad, guard, lat;

        tbl[0] = '{"n37_sat",    0, 16'h4000, 37, 16'h7FFF};
        tbl[1] = '{"bias_ramp",  1, 16'h4000, 99, 16'h0031};
        tbl[2] = '{"all_zero",   2, 16'h1234,  0, 16'h0000};
        tbl[3] = '{"all_min",    3, 16'h0000,  0, 16'h8000};
        tbl[4] = '{"tie_low",    4, 16'h7FFF, 12, 16'h1234};
        tbl[5] = '{"neg_mult",   5, 16'h8000, 63, 16'h7FFF};
        tbl[6] = '{"floor_shift",6, 16'hFFFF,  3, 16'hFFF6};

        for (int k = 0; k < P*LANES*M; k++) wB[k] = '0;
        for (int k = 0; k < P*LANES; k++)
            bB[k] = (k < 94) ? -16'sd100 : (k == 94) ? -16'sd1 : 16'sh7FFF;

        rst_n = 1'b0;
        ia.in_valid = 1'b0; ia.out_ready = 1'b0; ia.x = '0;
        ib.in_valid = 1'b0; ib.out_ready = 1'b0; ib.x = '0;

        // Reset values, before any clock edge.
        #3;
        check("rst_in_ready", ia.in_ready, 1'b1);
        check("rst_busy", ia.busy, 1'b0);
        check("rst_w_rd_en", ia.w_rd_en, 1'b0);
        check("rst_w_addr", ia.w_addr, 0);
        check("rst_out_valid", ia.out_valid, 1'b0);
        check("rst_outputs", {ia.y_onehot, ia.y_idx, ia.y_max}, 0);
        check("rst_state", ia.dbg_state, 2'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table of hand-derived vectors.
        for (int i = 0; i < 7; i++) begin
            load_pattern(tbl[i].pat);
            exp_q.push_back({IDXW'(tbl[i].exp_idx), tbl[i].exp_max});
            launch_a({M{tbl[i].x_fill}});
            check_result_a(tbl[i].name);
            release_a();
        end

        // Randomised vectors against the reference model.
        for (int r = 0; r < 8; r++) begin
            load_pattern((r % 2 == 0) ? 10 : 11);
            for (int j = 0; j < M; j++) xr[DW*j +: DW] = DW'($urandom);
            exp_q.push_back(ref_argmax(xr, N, 1'b0));
            launch_a(xr);
            check_result_a("rand");
            release_a();
        end

        // Back-pressure: result held for 20 cycles with a new vector waiting.
        load_pattern(11);
        for (int j = 0; j < M; j++) xr[DW*j +: DW] = DW'($urandom);
        for (int j = 0; j < M; j++) x2[DW*j +: DW] = DW'($urandom);
        exp_q.push_back(ref_argmax(xr, N, 1'b0));
        exp_q.push_back(ref_argmax(x2, N, 1'b0));
        launch_a(xr);
        check_result_a("hold_first");
        ia.x = x2;
        ia.in_valid = 1'b1;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (ia.y_idx !== last_exp[IDXW+DW-1:DW] || ia.y_max !== last_exp[DW-1:0] ||
                ia.out_valid !== 1'b1 || ia.in_ready !== 1'b0 || ia.busy !== 1'b1)
                bad++;
        end
        check("hold_stable_cycles_bad", bad, 0);
        release_a();
        launch_a(x2);
        check_result_a("hold_second");
        release_a();

        // Reset pulse in the 6th cycle of RUN aborts the vector.
        load_pattern(0);
        ia.x = {M{16'h4000}};
        ia.in_valid = 1'b1;
        guard = 0;
        while (ia.in_ready !== 1'b1 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        ia.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("pre_rst_w_rd_en", ia.w_rd_en, 1'b1);
        rst_n = 1'b0;
        #1;
        check("arst_w_rd_en", ia.w_rd_en, 1'b0);
        check("arst_busy_ready", {ia.busy, ia.in_ready}, 2'b01);
        check("arst_out_valid", ia.out_valid, 1'b0);
        check("arst_outputs", {ia.y_onehot, ia.y_idx, ia.y_max}, 0);
        check("arst_w_addr", ia.w_addr, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (ia.out_valid !== 1'b0 || ia.in_ready !== 1'b1) bad++;
        end
        check("post_rst_idle_cycles_bad", bad, 0);
        exp_q.push_back({IDXW'(37), 16'h7FFF});
        launch_a({M{16'h4000}});
        check_result_a("after_reset");
        release_a();

        // N=95: padding lanes 95..99 carry 0x7FFF and must be ignored.
        for (int j = 0; j < M; j++) xr[DW*j +: DW] = DW'($urandom);
        ib.x = xr;
        ib.in_valid = 1'b1;
        guard = 0;
        while (ib.in_ready !== 1'b1 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        ib.in_valid = 1'b0;
        lat = 0;
        while (ib.out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        ohb = '0;
        ohb[94] = 1'b1;
        check("pad_latency", lat, P + 4);
        check("pad_idx", ib.y_idx, 94);
        check("pad_max", ib.y_max, 16'hFFFF);
        check("pad_onehot", ib.y_onehot, ohb);
        check("pad_model", {ib.y_idx, ib.y_max}, ref_argmax(xr, NB, 1'b1));
        ib.out_ready = 1'b1;
        @(posedge clk); #1;
        ib.out_ready = 1'b0;
        check("pad_release", {ib.out_valid, ib.in_ready}, 2'b01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
